// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative shift/rotate sequencer around a 4-bit shifter_rotator.
// Optional abort input enabled by defining SHIFT_SEQ_ABORT_EN.

module shifter_rotator (
  input  logic [3:0] x,
  input  logic [1:0] select,
  output logic [3:0] y
);
  always_comb begin
    y = x;
    case (select)
      2'b00: y = {x[2:0], 1'b0};
      2'b01: y = {1'b0, x[3:1]};
      2'b10: y = {x[2:0], x[3]};
      2'b11: y = {x[0], x[3:1]};
      default: y = x;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [3:0]       din,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [3:0]       dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_y;
  logic             abort_hit;

  shifter_rotator u_shifter (
    .x      (data_q),
    .select (op_q),
    .y      (step_y)
  );

  always_comb begin
    abort_hit = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort_hit = abort;
`endif
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = din;
          op_d    = op;
          cnt_d   = count;
          state_d = (count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // An abort leaves the partially shifted value visible on dout.
        if (abort_hit) begin
          state_d = S_IDLE;
        end else begin
          data_d = step_y;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= 4'b0000;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign dout = data_q;

endmodule
